// File: rtl/vga_slot_loader.sv
// Copies a 2-bpp sprite bitmap from a sync ROM into a slot core, then programs x0/y0/ctrl/bypass.
// Latency: PIX_COUNT+7 cycles with load_ram, 5 without; no backpressure, one bus write per cycle.
module vga_slot_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int PIX_COUNT  = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  load_ram,
    input  logic                  bypass_in,
    input  logic [10:0]           x0_in,
    input  logic [10:0]           y0_in,
    input  logic [4:0]            ctrl_in,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [1:0]            rom_data,
    output logic                  cs,
    output logic                  write,
    output logic [13:0]           addr,
    output logic [31:0]           wr_data,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]         PIX_END  = CW'(PIX_COUNT);
    localparam logic [ADDR_WIDTH-1:0] ROM_LAST = ADDR_WIDTH'(PIX_COUNT - 1);
    localparam logic [13:0] REG_BYP  = 14'h2000;
    localparam logic [13:0] REG_X0   = 14'h2001;
    localparam logic [13:0] REG_Y0   = 14'h2002;
    localparam logic [13:0] REG_CTRL = 14'h2003;

    typedef enum logic [3:0] {
        IDLE, HIDE, PREFETCH, RAM_WR, WR_X0, WR_Y0, WR_CTRL, WR_BYP, DONE
    } state_t;

    state_t                state, state_nx;
    logic [CW-1:0]         cnt, cnt_nx;
    logic [ADDR_WIDTH-1:0] rom_addr_nx, rom_step;
    logic                  wr_nx;
    logic [13:0]           addr_nx;
    logic [31:0]           wr_data_nx;
    logic                  lat_byp;
    logic [10:0]           lat_x0, lat_y0;
    logic [4:0]            lat_ctrl;
    logic                  accept;

    assign accept   = (state == IDLE) && start;
    // Saturate so a full 2**ADDR_WIDTH load never wraps back to 0.
    assign rom_step = (rom_addr == ROM_LAST) ? rom_addr : rom_addr + ADDR_WIDTH'(1);

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        rom_addr_nx = rom_addr;
        wr_nx       = 1'b0;
        addr_nx     = 14'd0;
        wr_data_nx  = 32'd0;
        case (state)
            IDLE: begin
                if (start) begin
                    rom_addr_nx = '0;
                    cnt_nx      = '0;
                    wr_nx       = 1'b1;
                    if (load_ram) begin
                        state_nx   = HIDE;
                        addr_nx    = REG_BYP;
                        wr_data_nx = 32'd1;
                    end else begin
                        state_nx   = WR_X0;
                        addr_nx    = REG_X0;
                        wr_data_nx = {21'd0, x0_in};
                    end
                end
            end
            HIDE: begin
                state_nx    = PREFETCH;
                rom_addr_nx = rom_step;
            end
            PREFETCH: begin
                state_nx    = RAM_WR;
                rom_addr_nx = rom_step;
                wr_nx       = 1'b1;
                wr_data_nx  = {30'd0, rom_data};
                cnt_nx      = CW'(1);
            end
            RAM_WR: begin
                wr_nx = 1'b1;
                if (cnt == PIX_END) begin
                    state_nx   = WR_X0;
                    addr_nx    = REG_X0;
                    wr_data_nx = {21'd0, lat_x0};
                end else begin
                    rom_addr_nx = rom_step;
                    addr_nx     = 14'(cnt[ADDR_WIDTH-1:0]);
                    wr_data_nx  = {30'd0, rom_data};
                    cnt_nx      = cnt + CW'(1);
                end
            end
            WR_X0: begin
                state_nx   = WR_Y0;
                wr_nx      = 1'b1;
                addr_nx    = REG_Y0;
                wr_data_nx = {21'd0, lat_y0};
            end
            WR_Y0: begin
                state_nx   = WR_CTRL;
                wr_nx      = 1'b1;
                addr_nx    = REG_CTRL;
                wr_data_nx = {27'd0, lat_ctrl};
            end
            WR_CTRL: begin
                state_nx   = WR_BYP;
                wr_nx      = 1'b1;
                addr_nx    = REG_BYP;
                wr_data_nx = {31'd0, lat_byp};
            end
            WR_BYP:  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            rom_addr <= '0;
            cs       <= 1'b0;
            write    <= 1'b0;
            addr     <= 14'd0;
            wr_data  <= 32'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            lat_byp  <= 1'b0;
            lat_x0   <= 11'd0;
            lat_y0   <= 11'd0;
            lat_ctrl <= 5'd0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            rom_addr <= rom_addr_nx;
            cs       <= wr_nx;
            write    <= wr_nx;
            addr     <= addr_nx;
            wr_data  <= wr_data_nx;
            busy     <= (state_nx != IDLE) && (state_nx != DONE);
            done     <= (state_nx == DONE);
            if (accept) begin
                lat_byp  <= bypass_in;
                lat_x0   <= x0_in;
                lat_y0   <= y0_in;
                lat_ctrl <= ctrl_in;
            end
        end
    end

endmodule

// File: tb/tb_vga_slot_loader.sv
// Bench for vga_slot_loader: a 4-pixel instance and a default 1024-pixel instance.
// Expected slot writes are queued per instance and matched by a monitor on the falling edge.
module tb_vga_slot_loader;

    typedef struct {
        int          cyc;
        logic [13:0] a;
        logic [31:0] d;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start4 = 1'b0, startb = 1'b0;
    logic        load_ram = 1'b0, bypass_in = 1'b0;
    logic [10:0] x0_in = '0, y0_in = '0;
    logic [4:0]  ctrl_in = '0;

    logic [9:0]  rom_addr4, rom_addrb;
    logic [1:0]  rom_data4, rom_datab;
    logic        cs4, write4, busy4, done4;
    logic        csb, writeb, busyb, doneb;
    logic [13:0] addr4, addrb;
    logic [31:0] wdat4, wdatb;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    txn_t q4[$];
    txn_t qb[$];
    logic [1:0] rom4 [4] = '{2'd3, 2'd1, 2'd2, 2'd0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rom_data4 <= rom4[rom_addr4[1:0]];
    always @(posedge clk) rom_datab <= rom_addrb[1:0];

    vga_slot_loader #(.ADDR_WIDTH(10), .PIX_COUNT(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .load_ram(load_ram), .bypass_in(bypass_in),
        .x0_in(x0_in), .y0_in(y0_in), .ctrl_in(ctrl_in), .rom_addr(rom_addr4), .rom_data(rom_data4),
        .cs(cs4), .write(write4), .addr(addr4), .wr_data(wdat4), .busy(busy4), .done(done4));

    vga_slot_loader dut (
        .clk(clk), .reset(reset), .start(startb), .load_ram(load_ram), .bypass_in(bypass_in),
        .x0_in(x0_in), .y0_in(y0_in), .ctrl_in(ctrl_in), .rom_addr(rom_addrb), .rom_data(rom_datab),
        .cs(csb), .write(writeb), .addr(addrb), .wr_data(wdatb), .busy(busyb), .done(doneb));

    always @(negedge clk) begin
        if (cs4 === 1'b1 || write4 === 1'b1) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL wr4_unexpected cyc=%0d addr=%h data=%h expected no write", cyc, addr4, wdat4);
            end else begin
                txn_t t;
                t = q4.pop_front();
                if (cs4 !== 1'b1 || write4 !== 1'b1 || addr4 !== t.a || wdat4 !== t.d || cyc !== t.cyc) begin
                    errors++;
                    $display("FAIL wr4 got cyc=%0d cs=%b wr=%b addr=%h data=%h expected cyc=%0d addr=%h data=%h",
                             cyc, cs4, write4, addr4, wdat4, t.cyc, t.a, t.d);
                end
            end
        end
        if (csb === 1'b1 || writeb === 1'b1) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL wrb_unexpected cyc=%0d addr=%h data=%h expected no write", cyc, addrb, wdatb);
            end else begin
                txn_t t;
                t = qb.pop_front();
                if (csb !== 1'b1 || writeb !== 1'b1 || addrb !== t.a || wdatb !== t.d || cyc !== t.cyc) begin
                    errors++;
                    $display("FAIL wrb got cyc=%0d cs=%b wr=%b addr=%h data=%h expected cyc=%0d addr=%h data=%h",
                             cyc, csb, writeb, addrb, wdatb, t.cyc, t.a, t.d);
                end
            end
        end
    end

    function automatic void push_regs(ref txn_t q[$], input int c, input logic [10:0] x, input logic [10:0] y,
                                      input logic [4:0] ct, input logic b);
        q.push_back('{c,     14'h2001, {21'd0, x}});
        q.push_back('{c + 1, 14'h2002, {21'd0, y}});
        q.push_back('{c + 2, 14'h2003, {27'd0, ct}});
        q.push_back('{c + 3, 14'h2000, {31'd0, b}});
    endfunction

    function automatic void push_load4(int c0, logic [10:0] x, logic [10:0] y, logic [4:0] ct, logic b);
        q4.push_back('{c0 + 1, 14'h2000, 32'd1});
        for (int k = 0; k < 4; k++) q4.push_back('{c0 + 3 + k, 14'(k), {30'd0, rom4[k]}});
        push_regs(q4, c0 + 7, x, y, ct, b);
    endfunction

    // Queue the full 1024-pixel load, truncated at cycle lim.
    function automatic void push_full(int c0, int lim, logic [10:0] x, logic [10:0] y, logic [4:0] ct, logic b);
        qb.push_back('{c0 + 1, 14'h2000, 32'd1});
        for (int k = 0; k < 1024; k++)
            if (c0 + 3 + k <= lim) qb.push_back('{c0 + 3 + k, 14'(k), {30'd0, 2'(k)}});
        if (c0 + 1027 <= lim) push_regs(qb, c0 + 1027, x, y, ct, b);
    endfunction

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({cs4, write4, addr4, wdat4, rom_addr4, busy4, done4} !== '0 ||
            {csb, writeb, addrb, wdatb, rom_addrb, busyb, doneb} !== '0) begin
            errors++;
            $display("FAIL reset_state dut4=%h dutb=%h expected 0",
                     {cs4, write4, addr4, wdat4, rom_addr4, busy4, done4},
                     {csb, writeb, addrb, wdatb, rom_addrb, busyb, doneb});
        end
        start4 = 1'b1;
        load_ram = 1'b1;
        @(negedge clk);
        checks++;
        if (busy4 !== 1'b0 || cs4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_beats_start busy=%b cs=%b expected 0 0", busy4, cs4);
        end
        start4 = 1'b0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load4;
        int c0;
        @(negedge clk);
        load_ram = 1'b1; bypass_in = 1'b0; x0_in = 11'd100; y0_in = 11'd50; ctrl_in = 5'h04;
        start4 = 1'b1;
        c0 = cyc;
        push_load4(c0, 11'd100, 11'd50, 5'h04, 1'b0);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            start4 = 1'b0;
            checks++;
            if (busy4 !== (n <= 10) || done4 !== (n == 11)) begin
                errors++;
                $display("FAIL load4_status cycle %0d busy=%b done=%b expected %b %b", n, busy4, done4, n <= 10, n == 11);
            end
        end
        checks++;
        if (q4.size() != 0) begin
            errors++;
            $display("FAIL load4_missing %0d writes outstanding expected 0", q4.size());
        end
        q4.delete();
    endtask

    task automatic test_regs_only;
        int c0;
        @(negedge clk);
        load_ram = 1'b0; bypass_in = 1'b1; x0_in = 11'h7FF; y0_in = 11'd0; ctrl_in = 5'h1F;
        start4 = 1'b1;
        c0 = cyc;
        push_regs(q4, c0 + 1, 11'h7FF, 11'd0, 5'h1F, 1'b1);
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            start4 = 1'b0;
            checks++;
            if (done4 !== (n == 5) || busy4 !== (n <= 4) || rom_addr4 !== 10'd0) begin
                errors++;
                $display("FAIL regs_only cycle %0d done=%b busy=%b rom_addr=%0d expected %b %b 0",
                         n, done4, busy4, rom_addr4, n == 5, n <= 4);
            end
        end
        checks++;
        if (q4.size() != 0) begin
            errors++;
            $display("FAIL regs_only_missing %0d writes outstanding expected 0", q4.size());
        end
        q4.delete();
    endtask

    task automatic test_full;
        int c0, dcnt, dcyc;
        @(negedge clk);
        load_ram = 1'b1; bypass_in = 1'b1; x0_in = 11'h123; y0_in = 11'h045; ctrl_in = 5'h0A;
        startb = 1'b1;
        c0 = cyc;
        dcnt = 0;
        dcyc = 0;
        push_full(c0, c0 + 2000, 11'h123, 11'h045, 5'h0A, 1'b1);
        for (int n = 1; n <= 1035; n++) begin
            @(negedge clk);
            startb = 1'b0;
            if (doneb === 1'b1) begin
                dcnt++;
                dcyc = cyc;
            end
        end
        checks++;
        if (dcnt != 1 || dcyc != c0 + 1031) begin
            errors++;
            $display("FAIL full_done count=%0d at cycle %0d expected 1 at 1031", dcnt, dcyc - c0);
        end
        checks++;
        if (rom_addrb !== 10'd1023) begin
            errors++;
            $display("FAIL full_rom_addr got %0d expected 1023", rom_addrb);
        end
        checks++;
        if (qb.size() != 0) begin
            errors++;
            $display("FAIL full_missing %0d writes outstanding expected 0", qb.size());
        end
        qb.delete();
    endtask

    task automatic test_busy_restart;
        int c0, dcnt;
        @(negedge clk);
        load_ram = 1'b1; bypass_in = 1'b0; x0_in = 11'd100; y0_in = 11'd7; ctrl_in = 5'h03;
        start4 = 1'b1;
        c0 = cyc;
        dcnt = 0;
        push_load4(c0, 11'd100, 11'd7, 5'h03, 1'b0);
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            start4 = (n >= 3 && n < 6);
            if (n == 3) x0_in = 11'd555;
            if (done4 === 1'b1) dcnt++;
        end
        checks++;
        if (dcnt != 1) begin
            errors++;
            $display("FAIL busy_restart_done count=%0d expected 1", dcnt);
        end
        checks++;
        if (q4.size() != 0) begin
            errors++;
            $display("FAIL busy_restart_missing %0d writes outstanding expected 0", q4.size());
        end
        q4.delete();
    endtask

    task automatic test_reset_mid;
        int c0;
        @(negedge clk);
        load_ram = 1'b1; bypass_in = 1'b0; x0_in = 11'd1; y0_in = 11'd2; ctrl_in = 5'h01;
        startb = 1'b1;
        c0 = cyc;
        push_full(c0, c0 + 13, 11'd1, 11'd2, 5'h01, 1'b0);
        for (int n = 1; n <= 13; n++) begin
            @(negedge clk);
            startb = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (csb !== 1'b0 || busyb !== 1'b0 || doneb !== 1'b0 || addrb !== 14'd0 || rom_addrb !== 10'd0) begin
            errors++;
            $display("FAIL reset_mid cs=%b busy=%b done=%b addr=%h rom_addr=%0d expected all 0",
                     csb, busyb, doneb, addrb, rom_addrb);
        end
        reset = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            checks++;
            if (busyb !== 1'b0 || doneb !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_quiet busy=%b done=%b expected 0 0", busyb, doneb);
            end
        end
        checks++;
        if (qb.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_missing %0d writes outstanding expected 0", qb.size());
        end
        qb.delete();
        test_full();
    endtask

    task automatic test_back_to_back;
        int c0;
        @(negedge clk);
        load_ram = 1'b0; bypass_in = 1'b0; x0_in = 11'd321; y0_in = 11'd12; ctrl_in = 5'h05;
        start4 = 1'b1;
        c0 = cyc;
        push_regs(q4, c0 + 1, 11'd321, 11'd12, 5'h05, 1'b0);
        push_regs(q4, c0 + 7, 11'd321, 11'd12, 5'h05, 1'b0);
        for (int n = 1; n <= 13; n++) begin
            @(negedge clk);
            if (n == 7) start4 = 1'b0;
            checks++;
            if (done4 !== (n == 5 || n == 11) || busy4 !== ((n <= 4) || (n >= 7 && n <= 10))) begin
                errors++;
                $display("FAIL back_to_back cycle %0d done=%b busy=%b expected %b %b",
                         n, done4, busy4, n == 5 || n == 11, (n <= 4) || (n >= 7 && n <= 10));
            end
        end
        checks++;
        if (q4.size() != 0) begin
            errors++;
            $display("FAIL back_to_back_missing %0d writes outstanding expected 0", q4.size());
        end
        q4.delete();
    endtask

    initial begin
        test_reset();
        test_load4();
        test_regs_only();
        test_full();
        test_busy_restart();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
